// File: rtl/arith_pkg.sv
// Shared arithmetic-library package.
// Contents:
//   state_t   - sequencer states used by the bit-serial arithmetic blocks
//   cnt_width - width of a bit counter that must count 0..width with no wrap
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/half_subtractor.sv
// Half subtractor cell: d = a - b (one bit), bo = borrow out.
// Ports:
//   a  - minuend bit
//   b  - subtrahend bit
//   d  - difference bit (a ^ b)
//   bo - borrow out (~a & b)
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  assign d  = a ^ b;
  assign bo = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
// A full-subtractor slice built from two half_subtractor cells and an OR gate
// is fed from two right-shifting operand registers; the borrow is kept in a flop.
//
// Optional feature: define SERIAL_SUB_OVF_EN to capture the signed overflow
// flag; otherwise ovf is tied to 0.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - request a subtraction (accepted only in IDLE)
//   a, b    - minuend / subtrahend, sampled when start is accepted
//   busy    - high in SHIFT and DONE
//   done    - one-cycle pulse; results valid from this cycle
//   diff    - a - b modulo 2^WIDTH
//   borrow  - 1 iff a < b (unsigned)
//   ovf     - signed overflow (SERIAL_SUB_OVF_EN), else 0
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start; results from the last op held
// SHIFT | one result bit per cycle, WIDTH cycles
// DONE  | done pulse for one cycle, then back to IDLE
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt_q;
  logic             bin_q;
  logic             borrow_q;
  logic             last_bit;

  logic d0, bo0, d_bit, bo1, bout;

  half_subtractor u_hs0 (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .d  (d0),
    .bo (bo0)
  );

  half_subtractor u_hs1 (
    .a  (d0),
    .b  (bin_q),
    .d  (d_bit),
    .bo (bo1)
  );

  assign bout     = bo0 | bo1;
  assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      a_sr  <= a;
      b_sr  <= b;
      cnt_q <= '0;
      bin_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      bin_q  <= bout;
      cnt_q  <= cnt_q + CW'(1);
      if (last_bit) borrow_q <= bout;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // On the last bit the operand LSBs are the original MSBs and d_bit is the
  // result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= (a_sr[0] != b_sr[0]) && (d_bit != a_sr[0]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign diff   = res_sr;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=2 instances).
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_subtractor;

  localparam int W8 = 8;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic          start8, busy8, done8, borrow8, ovf8;
  logic [W8-1:0] a8, b8, diff8;

  logic          start2, busy2, done2, borrow2, ovf2;
  logic [W2-1:0] a2, b2, diff2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8),
    .ovf    (ovf8)
  );

  serial_subtractor #(.WIDTH(W2)) u_dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start2),
    .a      (a2),
    .b      (b2),
    .busy   (busy2),
    .done   (done2),
    .diff   (diff2),
    .borrow (borrow2),
    .ovf    (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ovf8(input logic [7:0] av, input logic [7:0] bv);
`ifdef SERIAL_SUB_OVF_EN
    int sa, sb, r;
    sa = av[7] ? int'(av) - 256 : int'(av);
    sb = bv[7] ? int'(bv) - 256 : int'(bv);
    r  = sa - sb;
    return (r > 127) || (r < -128);
`else
    return 1'b0;
`endif
  endfunction

  // One WIDTH=8 operation. If dup_at > 0, a second start (da, db) is pulsed
  // during the operation at that cycle and must be ignored.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input int dup_at, input logic [7:0] da, input logic [7:0] db);
    int          done_cnt, first_k;
    logic [7:0]  ediff, diff_at_done;
    logic        eb, eo, borrow_at_done, ovf_at_done;
    ediff = 8'((int'(av) - int'(bv)) & 255);
    eb    = (int'(av) < int'(bv));
    eo    = exp_ovf8(av, bv);
    done_cnt = 0;
    first_k  = -1;
    diff_at_done = '0;
    borrow_at_done = 1'b0;
    ovf_at_done = 1'b0;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    for (int k = 1; k <= W8 + 3; k++) begin
      if (k == dup_at) begin
        start8 = 1'b1; a8 = da; b8 = db;
      end else if (dup_at > 0 && k == dup_at + 1) begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (done8) begin
        done_cnt++;
        if (first_k < 0) begin
          first_k = k;
          diff_at_done = diff8;
          borrow_at_done = borrow8;
          ovf_at_done = ovf8;
        end
      end
      if (k == 1) check({tag, " busy_shift"}, 32'(busy8), 32'd1);
    end
    check({tag, " done_latency"}, 32'(first_k), 32'(W8));
    check({tag, " done_count"},   32'(done_cnt), 32'd1);
    check({tag, " diff"},         32'(diff_at_done), 32'(ediff));
    check({tag, " borrow"},       32'(borrow_at_done), 32'(eb));
    check({tag, " ovf"},          32'(ovf_at_done), 32'(eo));
    check({tag, " busy_idle"},    32'(busy8), 32'd0);
    check({tag, " diff_hold"},    32'(diff8), 32'(ediff));
    check({tag, " borrow_hold"},  32'(borrow8), 32'(eb));
  endtask

  task automatic op2(input logic [1:0] av, input logic [1:0] bv);
    int         first_k;
    logic [1:0] diff_at_done;
    logic       borrow_at_done;
    first_k = -1;
    diff_at_done = '0;
    borrow_at_done = 1'b0;
    @(negedge clk);
    a2 = av; b2 = bv; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int k = 1; k <= W2 + 3; k++) begin
      @(posedge clk); #1;
      if (done2 && first_k < 0) begin
        first_k = k;
        diff_at_done = diff2;
        borrow_at_done = borrow2;
      end
    end
    check($sformatf("w2 %0d-%0d latency", av, bv), 32'(first_k), 32'(W2));
    check($sformatf("w2 %0d-%0d diff", av, bv), 32'(diff_at_done),
          32'((int'(av) - int'(bv)) & 3));
    check($sformatf("w2 %0d-%0d borrow", av, bv), 32'(borrow_at_done),
          32'(int'(av) < int'(bv)));
  endtask

  initial begin
    int saw_done;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy",   32'(busy8),   32'd0);
    check("rst done",   32'(done8),   32'd0);
    check("rst diff",   32'(diff8),   32'd0);
    check("rst borrow", 32'(borrow8), 32'd0);
    check("rst ovf",    32'(ovf8),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op8("200-55",   8'd200,  8'd55,   0, 8'd0, 8'd0);
    op8("3-5",      8'd3,    8'd5,    0, 8'd0, 8'd0);
    op8("0-0",      8'd0,    8'd0,    0, 8'd0, 8'd0);
    op8("0-1",      8'd0,    8'd1,    0, 8'd0, 8'd0);
    op8("a==b",     8'd77,   8'd77,   0, 8'd0, 8'd0);
    op8("80-01",    8'h80,   8'h01,   0, 8'd0, 8'd0);
    op8("7f-ff",    8'h7F,   8'hFF,   0, 8'd0, 8'd0);
    op8("ignore",   8'd10,   8'd4,    3, 8'd1, 8'd9);

    // Reset mid-operation: start at edge 0, reset after edge 4.
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd2; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy8), 32'd0);
    check("abort diff", 32'(diff8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    saw_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W8 + 4; k++) begin
      @(posedge clk); #1;
      if (done8) saw_done = 1;
    end
    check("abort no_done", 32'(saw_done), 32'd0);
    op8("9-2 after rst", 8'd9, 8'd2, 0, 8'd0, 8'd0);

    for (int i = 0; i < 30; i++) begin
      op8($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 0, 8'd0, 8'd0);
    end

    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        op2(2'(x), 2'(y));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
